// File: rtl/jtag_master.sv
// -----------------------------------------------------------------------------
// jtag_master
//   JTAG initiator. Turns single-beat requests (TAP reset, idle cycles, IR shift,
//   DR shift) into TCK/TMS/TDI sequences and captures TDO. The TAP is always
//   left in Run-Test/Idle between requests.
//
//   Optional feature (macro JTAG_MASTER_NTRST_EN): the reset sequence is preceded
//   by 4 TCK periods with nTRST asserted. When undefined, jtag__ntrst is tied high.
//
// Parameters
//   DATA_WIDTH : maximum shift length in bits (<= 63, lengths are 6-bit)
//   TCK_HALF   : clk cycles per TCK half-period (>= 1)
//
// Ports
//   clk, reset            : system clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake (ready only while idle)
//   req_action            : 0=TAP reset, 1=idle cycles, 2=shift IR, 3=shift DR
//   req_length            : bits to shift / idle TCK periods (0 treated as 1)
//   req_data              : TDI data, bit 0 shifted first
//   resp_valid/resp_data  : one-cycle completion pulse, captured TDO
//   jtag__tck/tms/tdi/ntrst : JTAG pins driven towards the TAP
//   tdo                   : TDO from the TAP
// -----------------------------------------------------------------------------
module jtag_master #(
  parameter int DATA_WIDTH = 50,
  parameter int TCK_HALF   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_action,
  input  logic [5:0]            req_length,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  jtag__tck,
  output logic                  jtag__tms,
  output logic                  jtag__tdi,
  output logic                  jtag__ntrst,
  input  logic                  tdo
);

  localparam int             PH_W     = $clog2(2 * TCK_HALF);
  localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_HALF - 1);      // last low-phase cycle
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_HALF - 1);  // last cycle of a period
  localparam logic [5:0]     LEN_MAX  = 6'(DATA_WIDTH);

`ifdef JTAG_MASTER_NTRST_EN
  // 4 nTRST periods followed by 5 TMS=1 periods; DONE supplies the final TMS=0.
  localparam logic [5:0] NTRST_PERIODS = 6'd4;
  localparam logic [5:0] RST_LAST      = 6'd8;
`else
  localparam logic [5:0] RST_LAST      = 6'd4;
`endif

  typedef enum logic [2:0] {
    RESET_SEQ, IDLE, PREAMBLE, SHIFT, POSTAMBLE, IDLE_CYC, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [PH_W-1:0]         ph_q;       // clk cycle within the current TCK period
  logic [5:0]              cnt_q;      // TCK period index within the current state
  logic                    is_ir_q;
  logic [5:0]              len_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [DATA_WIDTH-1:0]   cap_q;
  logic                    resp_en_q;  // low for the automatic post-reset sequence
  logic                    resp_valid_q;
  logic [DATA_WIDTH-1:0]   resp_data_q;

  logic       accept;
  logic       period_end;
  logic [5:0] len_nz;
  logic [5:0] req_n;

  assign accept     = req_valid && (state_q == IDLE);
  assign period_end = (state_q != IDLE) && (ph_q == PH_LAST);

  // Effective length: zero means one; shift lengths clamp to the data width.
  always_comb begin
    len_nz = (req_length == 6'd0) ? 6'd1 : req_length;
    req_n  = len_nz;
    if (req_action[1] && (len_nz > LEN_MAX)) req_n = LEN_MAX;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_SEQ;
      ph_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= (state_q == IDLE || period_end) ? '0 : ph_q + 1'b1;
      if (state_d != state_q) cnt_q <= '0;
      else if (period_end)    cnt_q <= cnt_q + 6'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks assign every output a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RESET_SEQ: if (period_end && cnt_q == RST_LAST) state_d = DONE;
      IDLE: begin
        if (req_valid) begin
          unique case (req_action)
            2'd0:    state_d = RESET_SEQ;
            2'd1:    state_d = (req_n == 6'd1) ? DONE : IDLE_CYC;
            default: state_d = PREAMBLE;
          endcase
        end
      end
      IDLE_CYC:  if (period_end && cnt_q == len_q - 6'd2) state_d = DONE;
      PREAMBLE:  if (period_end && cnt_q == (is_ir_q ? 6'd3 : 6'd2)) state_d = SHIFT;
      SHIFT:     if (period_end && cnt_q == len_q - 6'd1) state_d = POSTAMBLE;
      POSTAMBLE: if (period_end) state_d = DONE;
      DONE:      if (period_end) state_d = IDLE;
      default:   state_d = RESET_SEQ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: pins are decoded from registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = (state_q == IDLE);
    jtag__tck = (state_q != IDLE) && (ph_q > PH_RISE);
    jtag__tms = 1'b0;
    jtag__tdi = 1'b0;
    unique case (state_q)
      RESET_SEQ: jtag__tms = 1'b1;
      // IR: Select-DR, Select-IR, Capture-IR, Shift-IR. DR: Select-DR, Capture-DR, Shift-DR.
      PREAMBLE:  jtag__tms = is_ir_q ? (cnt_q < 6'd2) : (cnt_q == 6'd0);
      SHIFT: begin
        jtag__tms = (cnt_q == len_q - 6'd1);  // Exit1 on the last bit
        jtag__tdi = data_q[cnt_q];
      end
      POSTAMBLE: jtag__tms = 1'b1;            // Update
      default:   jtag__tms = 1'b0;            // Run-Test/Idle
    endcase
`ifdef JTAG_MASTER_NTRST_EN
    // Held high while reset is asserted; asserted for the first periods of the sequence.
    jtag__ntrst = !(!reset && state_q == RESET_SEQ && cnt_q < NTRST_PERIODS);
`else
    jtag__ntrst = 1'b1;
`endif
  end

  // ---------------------------------------------------------------------------
  // Request datapath
  // ---------------------------------------------------------------------------
  // NOTE: these registers are always loaded on accept before they are used, so
  // they carry no reset; only control and visible outputs are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_ir_q <= (req_action == 2'd2);
      len_q   <= req_n;
      data_q  <= req_data;
      cap_q   <= '0;
    end else if (state_q == SHIFT && ph_q == PH_RISE) begin
      cap_q[cnt_q] <= tdo;  // sampled on the edge where TCK rises
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_en_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        resp_en_q <= 1'b1;
      end else if (state_q == DONE && period_end) begin
        resp_en_q    <= 1'b0;
        resp_valid_q <= resp_en_q;
        if (resp_en_q) resp_data_q <= cap_q;
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_jtag_master.sv
// -----------------------------------------------------------------------------
// tb_jtag_master
//   Directed bench for jtag_master (DATA_WIDTH=50, TCK_HALF=2). A negedge
//   monitor logs TMS/TDI at each TCK rise and can model a 1-bit bypass register
//   on TDO (TDI sampled on TCK rise, presented on TCK fall).
// -----------------------------------------------------------------------------
module tb_jtag_master;
  localparam int DW = 50;
  localparam int TH = 2;
`ifdef JTAG_MASTER_NTRST_EN
  localparam int          RST_P     = 10;
  localparam logic [63:0] RST_TMS   = 64'h1FF;
  localparam int          NTRST_LOW = 16;
`else
  localparam int          RST_P     = 6;
  localparam logic [63:0] RST_TMS   = 64'h1F;
  localparam int          NTRST_LOW = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_action = 2'd0;
  logic [5:0]    req_length = 6'd0;
  logic [DW-1:0] req_data = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          jtag__tck, jtag__tms, jtag__tdi, jtag__ntrst;
  logic          tdo;

  logic tdo_mode  = 1'b0;  // 0: constant, 1: bypass model
  logic tdo_const = 1'b0;

  jtag_master #(.DATA_WIDTH(DW), .TCK_HALF(TH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_action (req_action),
    .req_length (req_length),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .jtag__tck  (jtag__tck),
    .jtag__tms  (jtag__tms),
    .jtag__tdi  (jtag__tdi),
    .jtag__ntrst(jtag__ntrst),
    .tdo        (tdo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / TAP-side model
  logic tck_prev = 1'b0;
  logic bp = 1'b0;
  logic bp_out = 1'b0;
  bit   tms_log [512];
  bit   tdi_log [512];
  int   nrise = 0;
  int   nresp = 0;
  int   nlow  = 0;

  always @(negedge clk) begin
    if (jtag__tck && !tck_prev) begin
      if (nrise < 512) begin
        tms_log[nrise] <= jtag__tms;
        tdi_log[nrise] <= jtag__tdi;
      end
      nrise <= nrise + 1;
      bp    <= jtag__tdi;
    end
    if (!jtag__tck && tck_prev) bp_out <= bp;
    if (resp_valid) nresp <= nresp + 1;
    if (!jtag__ntrst) nlow <= nlow + 1;
    tck_prev <= jtag__tck;
  end

  assign tdo = tdo_mode ? bp_out : tdo_const;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] log_bits(input bit sel_tdi, input int start, input int n);
    logic [63:0] r = '0;
    for (int i = 0; i < n && i < 64; i++)
      if (start + i < 512) r[i] = sel_tdi ? tdi_log[start + i] : tms_log[start + i];
    return r;
  endfunction

  task automatic wait_ready(input int limit);
    int w = 0;
    while (!req_ready && w < limit) begin
      tick();
      w++;
    end
  endtask

  task automatic wait_resp(input int limit);
    int w = 0;
    while (!resp_valid && w < limit) begin
      tick();
      w++;
    end
  endtask

  int req_n0;  // nrise at the accept of the last do_req

  // Issue one request, check latency, period count, response data and ready.
  task automatic do_req(input logic [1:0] act, input logic [5:0] len, input logic [DW-1:0] data,
                        input int exp_p, input logic [63:0] exp_resp, input string tag);
    int acc;
    wait_ready(200);
    req_valid  = 1'b1;
    req_action = act;
    req_length = len;
    req_data   = data;
    acc        = cyc;
    req_n0     = nrise;
    tick();
    req_valid  = 1'b0;
    req_action = ~act;
    req_length = ~len;
    req_data   = ~data;
    wait_resp(1000);
    check({tag, "_latency"}, 64'(cyc - acc), 64'(1 + 2 * TH * exp_p));
    check({tag, "_periods"}, 64'(nrise - req_n0), 64'(exp_p));
    check({tag, "_resp_data"}, 64'(resp_data), exp_resp);
    check({tag, "_ready_at_resp"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int rel, n1, r0, l0, acc, acc2;

    // ---- reset values ----
    repeat (3) tick();
    check("rst_tck", 64'(jtag__tck), 64'd0);
    check("rst_tms", 64'(jtag__tms), 64'd1);
    check("rst_tdi", 64'(jtag__tdi), 64'd0);
    check("rst_ntrst", 64'(jtag__ntrst), 64'd1);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);

    // ---- automatic TAP reset after release ----
    reset = 1'b0;
    rel = cyc;
    n1  = nrise;
    l0  = nlow;
    wait_ready(200);
    check("auto_ready_cycle", 64'(cyc - rel), 64'(2 * TH * RST_P));
    check("auto_periods", 64'(nrise - n1), 64'(RST_P));
    check("auto_tms", log_bits(1'b0, n1, RST_P), RST_TMS);
    check("auto_no_resp", 64'(nresp), 64'd0);
    check("auto_ntrst_low", 64'(nlow - l0), 64'(NTRST_LOW));

    // ---- IR shift, 5 bits of 0x12 ----
    tdo_mode = 1'b0; tdo_const = 1'b0;
    do_req(2'd2, 6'd5, DW'(50'h12), 11, 64'h0, "ir5");
    check("ir5_tms", log_bits(1'b0, req_n0, 11), 64'h303);
    check("ir5_tdi", log_bits(1'b1, req_n0, 11), 64'h120);

    // ---- DR shifts with TDO high: normal and clamped lengths ----
    tdo_const = 1'b1;
    do_req(2'd3, 6'd8, '0, 13, 64'hFF, "dr8");
    check("dr8_tms", log_bits(1'b0, req_n0, 13), 64'hC01);
    do_req(2'd3, 6'd60, '0, 55, 64'h3_FFFF_FFFF_FFFF, "dr60");

    // ---- DR through a bypass bit: TDO lags TDI by one period ----
    tdo_mode = 1'b1;
    do_req(2'd3, 6'd12, DW'(50'hA5C), 17, 64'h4B8, "dr_bypass");
    check("dr_bypass_tdi", log_bits(1'b1, req_n0 + 3, 12), 64'hA5C);
    repeat (3) tick();
    check("hold_resp_data", 64'(resp_data), 64'h4B8);
    check("hold_resp_valid", 64'(resp_valid), 64'd0);
    tdo_mode = 1'b0; tdo_const = 1'b0;

    // ---- idle length 0 behaves as 1 ----
    do_req(2'd1, 6'd0, '0, 1, 64'h0, "idle0");
    check("idle0_tms", log_bits(1'b0, req_n0, 1), 64'h0);

    // ---- TAP reset action: responds, resp_data cleared ----
    l0 = nlow;
    do_req(2'd0, 6'd5, '1, RST_P, 64'h0, "rst_act");
    check("rst_act_tms", log_bits(1'b0, req_n0, RST_P), RST_TMS);
    check("rst_act_ntrst_low", 64'(nlow - l0), 64'(NTRST_LOW));

    // ---- idle 3 followed by a back-to-back DR request ----
    wait_ready(200);
    req_valid = 1'b1; req_action = 2'd1; req_length = 6'd3; req_data = '0;
    acc = cyc;
    n1  = nrise;
    tick();
    req_action = 2'd3; req_length = 6'd4; req_data = DW'(50'hF);
    wait_resp(200);
    check("b2b_idle_latency", 64'(cyc - acc), 64'd13);
    check("b2b_idle_tms", log_bits(1'b0, n1, 3), 64'h0);
    check("b2b_ready_with_resp", 64'(req_ready), 64'd1);
    acc2 = cyc;
    n1   = nrise;
    tick();
    check("b2b_dr_accepted", 64'(req_ready), 64'd0);
    req_valid = 1'b0;
    wait_resp(200);
    check("b2b_dr_latency", 64'(cyc - acc2), 64'd37);
    check("b2b_dr_tms", log_bits(1'b0, n1, 9), 64'hC1);

    // ---- reset during the 20th DR shift bit ----
    tdo_const = 1'b1;
    wait_ready(200);
    req_valid = 1'b1; req_action = 2'd3; req_length = 6'd30; req_data = '0;
    n1 = nrise;
    r0 = nresp;
    tick();
    req_valid = 1'b0;
    for (int w = 0; w < 500 && nrise < n1 + 23; w++) tick();
    check("mid_reached_bit20", 64'(nrise - n1), 64'd23);
    reset = 1'b1;
    tick();
    check("mid_tck", 64'(jtag__tck), 64'd0);
    check("mid_tms", 64'(jtag__tms), 64'd1);
    check("mid_ready", 64'(req_ready), 64'd0);
    check("mid_resp_data", 64'(resp_data), 64'd0);
    reset = 1'b0;
    rel = cyc;
    n1  = nrise;
    wait_ready(200);
    check("mid_replay_cycle", 64'(cyc - rel), 64'(2 * TH * RST_P));
    check("mid_replay_tms", log_bits(1'b0, n1, RST_P), RST_TMS);
    tick();
    check("mid_no_resp", 64'(nresp - r0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- JTAG initiator: drives TCK/TMS/TDI/nTRST into a JTAG TAP and samples TDO back.
- Converts single-beat requests (TAP reset, idle cycles, IR shift, DR shift) into the corresponding TMS/TDI sequences.
- Replaces the scripted test harness as the driver for the JTAG TAP + JTAG-APB bridge, giving benches and on-chip debug a programmatic JTAG access path.

Parameters:
- DATA_WIDTH, 50: maximum shift length in bits; width of req_data/resp_data.
- TCK_HALF, 2: clk cycles per TCK half-period (≥1).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid&req_ready
- req_action  input  2  0=TAP reset, 1=idle cycles, 2=shift IR, 3=shift DR
- req_length  input  6  bits to shift, or idle TCK periods
- req_data  input  DATA_WIDTH  TDI data, bit 0 shifted first
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  DATA_WIDTH  captured TDO, bit i = TDO of shift period i
- jtag__tck  output  1  TCK
- jtag__tms  output  1  TMS
- jtag__tdi  output  1  TDI
- jtag__ntrst  output  1  nTRST, active low
- tdo  input  1  TDO from TAP

Behaviour:
- **TCK period**
  - 2*TCK_HALF clk cycles: first TCK_HALF low, then TCK_HALF high.
  - TMS/TDI update on entry to the low phase.
  - TDO is sampled on the clk edge where TCK rises.
- **Reset values:** tck=0, tms=1, tdi=0, ntrst=1, req_ready=0, resp_valid=0, resp_data=0.
- **After reset:** FSM runs an automatic TAP-reset sequence (TMS 1,1,1,1,1,0); req_ready rises when it completes. No resp_valid for this auto sequence.
- **FSM states:** RESET_SEQ, IDLE, PREAMBLE, SHIFT, POSTAMBLE, IDLE_CYC, DONE. The TAP is always left in Run-Test/Idle between requests.
- **Request acceptance:** req_ready=1 only in IDLE. The request is captured at the accept edge; req_* are don't-care afterwards.
- **Per-action TMS sequences:**
  - Reset (action 0): TMS 1,1,1,1,1,0 → 6 periods.
  - Idle (action 1): TMS=0 for req_length periods.
  - IR (action 2): preamble TMS 1,1,0,0, then N shift periods with TMS=0 except TMS=1 on the last, then postamble TMS 1,0 → N+6 periods.
  - DR (action 3): preamble TMS 1,0,0 → N+5 periods.
- **Length rules:**
  - N = req_length, clamped to DATA_WIDTH.
  - req_length=0 is treated as 1, for both shift and idle.
- **TDI / TDO:**
  - TDI = req_data[i] during shift period i; TDI=0 outside shift periods.
  - resp_data[i] = sampled TDO for i<N; bits ≥N are 0.
  - resp_data=0 for reset and idle actions.
- **Completion timing:**
  - Request accepted at edge t, P periods total: first period starts at t+1.
  - resp_valid=1 at cycle t+1+2*TCK_HALF*P for exactly one cycle; resp_data is valid then and held until the next resp_valid.
  - FSM is in IDLE with req_ready=1 in that same cycle, so a back-to-back accept is allowed.
- **Shift counter:** 6-bit, counts 0..N-1. The last shift period is detected by compare with N-1; no wrap.
- **Reset mid-operation:**
  - tck=0 and tms=1 on the next cycle.
  - Outstanding request dropped; no resp_valid.
  - Auto TAP-reset sequence replays.

Optional Feature:
- **JTAG_MASTER_NTRST_EN defined:** action 0 and the auto reset sequence first drive jtag__ntrst=0 for 4 TCK periods (TCK toggling, TMS=1), then ntrst=1 and the normal 6-period sequence. Reset action total = 10 periods.
- **Undefined:** jtag__ntrst tied to 1; the nTRST logic is absent.

Test Plan (TCK_HALF=2, DATA_WIDTH=50, bench = jtag_master + jtag_tap + jtag_apb + apb_target_timer):
- Deassert reset → 6 TCK pulses with TMS 1,1,1,1,1,0; req_ready rises at cycle 24 after reset release; no resp_valid.
- Shift IR, length 5, data 0x12 → 11 periods; resp_valid exactly 44 cycles after accept+1; tap ir==5'h12 after Update-IR.
- tdo tied 1, shift DR length 8 data 0 → resp_data=0xFF with bits 49:8 zero. Repeat with length 60 → clamped to 50, resp_data=2^50-1, 55 periods.
- Idle length 3, then immediately a DR request held valid → TMS 0,0,0; resp_valid at accept+13; DR request accepted in that same cycle.
- Assert reset during the 20th DR shift bit → next cycle tck=0, tms=1; no resp_valid; 6-period reset sequence replays, then req_ready=1.
- With JTAG_MASTER_NTRST_EN, reset action → ntrst=0 for 16 clk cycles (4 periods), then 6 TMS periods; resp_valid 40 cycles after accept+1.
